// File: rtl/tinyqv_qspi_mem_responder.sv
// QSPI memory responder: decodes quad read/write transactions into an internal byte array,
// with a backdoor port for preload/inspection. Define QSPI_RESP_ERR_EN to add err_count.
//
// state  | meaning
// IDLE   | deselected, or waiting for a fresh select after reset
// CMD    | collecting the two opcode nibbles
// ADDR   | collecting six address nibbles
// DUMMY  | turnaround rises before read data
// READ   | driving array nibbles on every spi_clk fall
// WRITE  | committing a byte on every second rise
// IGNORE | unknown opcode, idle until deselect
module tinyqv_qspi_mem_responder #(
    parameter int ADDR_BITS = 12,
    parameter int DUMMY_NIBBLES = 4,
    parameter logic [7:0] READ_CMD = 8'h0B,
    parameter logic [7:0] WRITE_CMD = 8'h02
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 spi_clk,
    input  logic                 spi_cs_n,
    input  logic [3:0]           spi_data_in,
    output logic [3:0]           spi_data_out,
    output logic [3:0]           spi_data_oe,
    output logic                 txn_active,
    input  logic                 bd_we,
    input  logic [ADDR_BITS-1:0] bd_addr,
    input  logic [7:0]           bd_wdata,
    output logic [7:0]           bd_rdata
`ifdef QSPI_RESP_ERR_EN
    ,
    output logic [7:0]           err_count
`endif
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, READ, WRITE, IGNORE} state_t;

    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_NIBBLES - 1);

    logic [7:0] mem [2**ADDR_BITS];

    state_t state, state_n;
    logic sclk_q, rise, fall;
    logic [7:0] cnt, cnt_n;
    logic [3:0] cmd_hi, cmd_hi_n;
    logic [3:0] wr_hi, wr_hi_n;
    logic is_write, is_write_n;
    logic half, half_n;
    logic desel_wait, desel_wait_n;
    logic [ADDR_BITS-1:0] addr, addr_n;
    logic [3:0] data_out_n, data_oe_n;
    logic spi_we;
    logic [7:0] rd_byte;

    assign rise = spi_clk & ~sclk_q;
    assign fall = ~spi_clk & sclk_q;
    assign rd_byte = mem[addr];
    assign txn_active = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            sclk_q <= 1'b0;
            cnt <= '0;
            cmd_hi <= '0;
            wr_hi <= '0;
            is_write <= 1'b0;
            half <= 1'b0;
            desel_wait <= 1'b1;
            addr <= '0;
            spi_data_out <= '0;
            spi_data_oe <= '0;
        end else begin
            state <= state_n;
            sclk_q <= spi_clk;
            cnt <= cnt_n;
            cmd_hi <= cmd_hi_n;
            wr_hi <= wr_hi_n;
            is_write <= is_write_n;
            half <= half_n;
            desel_wait <= desel_wait_n;
            addr <= addr_n;
            spi_data_out <= data_out_n;
            spi_data_oe <= data_oe_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        cmd_hi_n = cmd_hi;
        wr_hi_n = wr_hi;
        is_write_n = is_write;
        half_n = half;
        desel_wait_n = desel_wait;
        addr_n = addr;
        data_out_n = spi_data_out;
        data_oe_n = spi_data_oe;
        spi_we = 1'b0;

        if (spi_cs_n) begin
            state_n = IDLE;
            cnt_n = '0;
            half_n = 1'b0;
            data_oe_n = '0;
            desel_wait_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // after reset the host must deselect before a new command is accepted
                    if (!desel_wait) begin
                        state_n = CMD;
                        cnt_n = '0;
                        half_n = 1'b0;
                    end
                end
                CMD: begin
                    if (rise) begin
                        cmd_hi_n = spi_data_in;
                        cnt_n = cnt + 8'd1;
                        if (cnt[0]) begin
                            cnt_n = '0;
                            if ({cmd_hi, spi_data_in} == READ_CMD) begin
                                state_n = ADDR;
                                is_write_n = 1'b0;
                            end else if ({cmd_hi, spi_data_in} == WRITE_CMD) begin
                                state_n = ADDR;
                                is_write_n = 1'b1;
                            end else begin
                                state_n = IGNORE;
                            end
                        end
                    end
                end
                ADDR: begin
                    if (rise) begin
                        addr_n = {addr[ADDR_BITS-5:0], spi_data_in};
                        cnt_n = cnt + 8'd1;
                        if (cnt == 8'd5) begin
                            cnt_n = '0;
                            if (is_write)
                                state_n = WRITE;
                            else if (DUMMY_NIBBLES == 0)
                                state_n = READ;
                            else
                                state_n = DUMMY;
                        end
                    end
                end
                DUMMY: begin
                    if (rise) begin
                        cnt_n = cnt + 8'd1;
                        if (cnt == DUMMY_LAST) begin
                            cnt_n = '0;
                            state_n = READ;
                        end
                    end
                end
                READ: begin
                    if (fall) begin
                        data_oe_n = 4'hF;
                        if (!half) begin
                            data_out_n = rd_byte[7:4];
                            half_n = 1'b1;
                        end else begin
                            data_out_n = rd_byte[3:0];
                            half_n = 1'b0;
                            addr_n = addr + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (rise) begin
                        if (!half) begin
                            wr_hi_n = spi_data_in;
                            half_n = 1'b1;
                        end else begin
                            spi_we = 1'b1;
                            half_n = 1'b0;
                            addr_n = addr + 1'b1;
                        end
                    end
                end
                default: begin
                    data_oe_n = '0;
                end
            endcase
        end
    end

    // SPI write is issued last so it overrides a same-address backdoor write
    always_ff @(posedge clk) begin
        if (bd_we)
            mem[bd_addr] <= bd_wdata;
        if (spi_we)
            mem[addr] <= {wr_hi, spi_data_in};
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            bd_rdata <= '0;
        else
            bd_rdata <= mem[bd_addr];
    end

`ifdef QSPI_RESP_ERR_EN
    logic err_end;
    assign err_end = spi_cs_n && ((state == IGNORE) || (state == CMD) || (state == ADDR) ||
                                  (state == WRITE && half));

    always_ff @(posedge clk) begin
        if (!rstn)
            err_count <= '0;
        else if (err_end && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_tinyqv_qspi_mem_responder.sv
// Directed bench for tinyqv_qspi_mem_responder: host-side QSPI driver, byte-array model and
// a nibble scoreboard for read data.
module tb_tinyqv_qspi_mem_responder;

    logic clk = 1'b0;
    logic rstn;
    logic spi_clk;
    logic spi_cs_n;
    logic [3:0] spi_data_in;
    logic [3:0] spi_data_out;
    logic [3:0] spi_data_oe;
    logic txn_active;
    logic bd_we;
    logic [11:0] bd_addr;
    logic [7:0] bd_wdata;
    logic [7:0] bd_rdata;
`ifdef QSPI_RESP_ERR_EN
    logic [7:0] err_count;
`endif

    int n_tests = 0;
    int n_fail = 0;
    logic [7:0] model [4096];
    logic [3:0] exp_q [$];

    always #5 clk = ~clk;

    tinyqv_qspi_mem_responder dut (
        .clk(clk),
        .rstn(rstn),
        .spi_clk(spi_clk),
        .spi_cs_n(spi_cs_n),
        .spi_data_in(spi_data_in),
        .spi_data_out(spi_data_out),
        .spi_data_oe(spi_data_oe),
        .txn_active(txn_active),
        .bd_we(bd_we),
        .bd_addr(bd_addr),
        .bd_wdata(bd_wdata),
        .bd_rdata(bd_rdata)
`ifdef QSPI_RESP_ERR_EN
        ,
        .err_count(err_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [3:0] nib);
        spi_data_in = nib;
        spi_clk = 1'b1;
        wait_clk(3);
        spi_clk = 1'b0;
        wait_clk(3);
    endtask

    task automatic send_byte(input logic [7:0] b);
        pulse(b[7:4]);
        pulse(b[3:0]);
    endtask

    task automatic send_addr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) pulse(a[i*4 +: 4]);
    endtask

    task automatic select();
        spi_cs_n = 1'b0;
        wait_clk(3);
    endtask

    task automatic deselect();
        spi_cs_n = 1'b1;
        wait_clk(3);
    endtask

    task automatic bd_write(input logic [11:0] a, input logic [7:0] d);
        bd_addr = a;
        bd_wdata = d;
        bd_we = 1'b1;
        wait_clk(1);
        bd_we = 1'b0;
        model[a] = d;
    endtask

    task automatic bd_check(input string tag, input logic [11:0] a, input logic [7:0] exp);
        bd_addr = a;
        wait_clk(2);
        chk(tag, 32'(bd_rdata), 32'(exp));
    endtask

    task automatic spi_read(input string tag, input logic [23:0] a, input int nbytes);
        logic [11:0] ma;
        logic [3:0] e;
        select();
        send_byte(8'h0B);
        send_addr(a);
        for (int i = 0; i < 4; i++) pulse(4'h0);
        for (int i = 0; i < nbytes; i++) begin
            ma = 12'(a[11:0] + 12'(i));
            exp_q.push_back(model[ma][7:4]);
            exp_q.push_back(model[ma][3:0]);
        end
        for (int k = 0; k < 2 * nbytes; k++) begin
            e = exp_q.pop_front();
            chk({tag, " data"}, 32'(spi_data_out), 32'(e));
            chk({tag, " oe"}, 32'(spi_data_oe), 32'hF);
            if (k != 2 * nbytes - 1) pulse(4'h0);
        end
        chk({tag, " txn_active"}, 32'(txn_active), 32'h1);
        deselect();
        chk({tag, " idle"}, 32'(txn_active), 32'h0);
    endtask

    initial begin
        rstn = 1'b0;
        spi_clk = 1'b0;
        spi_cs_n = 1'b0;
        spi_data_in = 4'h0;
        bd_we = 1'b0;
        bd_addr = '0;
        bd_wdata = '0;
        for (int i = 0; i < 4096; i++) model[i] = 8'h00;

        // reset held with select asserted: responder must stay idle until a deselect
        wait_clk(2);
        chk("rst oe", 32'(spi_data_oe), 32'h0);
        chk("rst txn_active", 32'(txn_active), 32'h0);
        chk("rst data_out", 32'(spi_data_out), 32'h0);
        chk("rst bd_rdata", 32'(bd_rdata), 32'h0);
        rstn = 1'b1;
        wait_clk(2);
        send_byte(8'h02);
        send_byte(8'h00);
        chk("post-rst still idle", 32'(txn_active), 32'h0);
        chk("post-rst oe", 32'(spi_data_oe), 32'h0);
        deselect();
`ifdef QSPI_RESP_ERR_EN
        chk("err after reset", 32'(err_count), 32'h0);
`endif

        for (int i = 0; i < 4096; i++) bd_write(12'(i), 8'h00);

        // write two bytes then read them back through SPI and the backdoor
        select();
        send_byte(8'h02);
        send_addr(24'h000010);
        chk("wr txn_active", 32'(txn_active), 32'h1);
        send_byte(8'hA5);
        send_byte(8'h3C);
        deselect();
        model[12'h010] = 8'hA5;
        model[12'h011] = 8'h3C;
        spi_read("rd 010", 24'h000010, 2);
        bd_check("bd 010", 12'h010, 8'hA5);
        bd_check("bd 011", 12'h011, 8'h3C);

        // address wrap at the top of the array
        bd_write(12'hFFF, 8'h11);
        bd_write(12'h000, 8'h22);
        spi_read("wrap", 24'h000FFF, 2);

        // upper address bits ignored
        bd_write(12'h123, 8'h9E);
        spi_read("hi addr", 24'hABC123, 1);

        // unknown opcode: no drive, no write
        select();
        send_byte(8'h9F);
        send_addr(24'h000010);
        send_byte(8'h77);
        chk("ill oe", 32'(spi_data_oe), 32'h0);
        chk("ill txn_active", 32'(txn_active), 32'h1);
        deselect();
        bd_check("ill mem 010", 12'h010, 8'hA5);
        bd_check("ill mem 011", 12'h011, 8'h3C);
`ifdef QSPI_RESP_ERR_EN
        chk("err after illegal", 32'(err_count), 32'h1);
`endif

        // aborted write with a single nibble leaves the byte untouched
        bd_write(12'h020, 8'h5A);
        select();
        send_byte(8'h02);
        send_addr(24'h000020);
        pulse(4'h7);
        deselect();
        bd_check("abort 020", 12'h020, 8'h5A);
`ifdef QSPI_RESP_ERR_EN
        chk("err after abort", 32'(err_count), 32'h2);
`endif

        // backdoor/SPI collisions on the commit cycle
        bd_write(12'h040, 8'h00);
        select();
        send_byte(8'h02);
        send_addr(24'h000030);
        pulse(4'hE);
        spi_data_in = 4'hE;
        bd_addr = 12'h030;
        bd_wdata = 8'h11;
        bd_we = 1'b1;
        spi_clk = 1'b1;
        wait_clk(1);
        bd_we = 1'b0;
        wait_clk(2);
        spi_clk = 1'b0;
        wait_clk(3);
        pulse(4'h4);
        spi_data_in = 4'h4;
        bd_addr = 12'h040;
        bd_wdata = 8'h77;
        bd_we = 1'b1;
        spi_clk = 1'b1;
        wait_clk(1);
        bd_we = 1'b0;
        wait_clk(2);
        spi_clk = 1'b0;
        wait_clk(3);
        deselect();
        model[12'h030] = 8'hEE;
        model[12'h031] = 8'h44;
        model[12'h040] = 8'h77;
        bd_check("collide same", 12'h030, 8'hEE);
        bd_check("collide next", 12'h031, 8'h44);
        bd_check("collide other", 12'h040, 8'h77);
        spi_read("rd 030", 24'h000030, 2);

        chk("exp queue drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
